// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the request arbiter.
package arbiter_pkg;

    typedef enum logic {ARB_RR, ARB_FIXED} arb_mode_e;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    // Width of the hold counter; large enough for MAX_HOLD up to 255.
    localparam int unsigned HOLD_W = 8;

    // Increment an index modulo n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: first set request at or above ptr, wrapping,
// optionally skipping one index (the current owner).
module arb_pick
    import arbiter_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [$clog2(N)-1:0] mask_idx,
    input  logic                 mask_en,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned IDW = $clog2(N);

    // Scan N candidates starting at ptr; the first eligible one wins.
    always_comb begin
        int unsigned c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            c = 32'(ptr) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!found && req[c] && !(mask_en && (c == 32'(mask_idx)))) begin
                found = 1'b1;
                idx   = c[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with a bounded hold time.
// The owner keeps the grant while it requests, until it has held for
// MAX_HOLD cycles and someone else is waiting.
module rr_arbiter
    import arbiter_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter arb_mode_e   MODE     = ARB_RR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id
);

    localparam int unsigned     IDW      = $clog2(N);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [IDW-1:0]    owner_d;
    logic              take;

    logic [N-1:0]      grant_q, grant_d;
    logic              grant_valid_q, grant_valid_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;

    logic [IDW-1:0]    pick_ptr;
    logic              pick_found;
    logic [IDW-1:0]    pick_idx;

    // Fixed priority is a search that always starts at index 0.
    assign pick_ptr = (MODE == ARB_FIXED) ? '0 : ptr_q;

    // While busy the owner is masked so a handover always finds someone else.
    arb_pick #(
        .N (N)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask_idx (grant_id_q),
        .mask_en  (state_q == BUSY),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_q        <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    // Next-state: decide whether to keep the owner, hand over, or go idle.
    always_comb begin
        state_d = state_q;
        owner_d = grant_id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    take = 1'b1;
                end
            end
            BUSY: begin
                if (!req[grant_id_q]) begin
                    // Owner released: hand over in the same edge, no bubble.
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((hold_q == HOLD_MAX) && pick_found) begin
                    take = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = BUSY;
            owner_d = pick_idx;
            hold_d  = '0;
            ptr_d   = IDW'(wrap_inc(32'(pick_idx), N));
        end
    end

    // Outputs: decode the next owner into the registered grant bus.
    always_comb begin
        grant_d       = '0;
        grant_valid_d = (state_d == BUSY);
        grant_id_d    = '0;
        if (state_d == BUSY) begin
            grant_d[owner_d] = 1'b1;
            grant_id_d       = owner_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: three instances (round-robin, fixed, MAX_HOLD=1)
// share one request bus; a behavioural model feeds a scoreboard queue.
module tb_rr_arbiter;
    import arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;

    logic [3:0] g_rr, g_fx, g_h1;
    logic       v_rr, v_fx, v_h1;
    logic [1:0] id_rr, id_fx, id_h1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arbiter #(.N(4), .MAX_HOLD(4), .MODE(ARB_RR)) dut_rr (
        .clk(clk), .reset(reset), .req(req),
        .grant(g_rr), .grant_valid(v_rr), .grant_id(id_rr)
    );

    rr_arbiter #(.N(4), .MAX_HOLD(4), .MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .reset(reset), .req(req),
        .grant(g_fx), .grant_valid(v_fx), .grant_id(id_fx)
    );

    rr_arbiter #(.N(4), .MAX_HOLD(1), .MODE(ARB_RR)) dut_h1 (
        .clk(clk), .reset(reset), .req(req),
        .grant(g_h1), .grant_valid(v_h1), .grant_id(id_h1)
    );

    // owner = -1 means no grant
    typedef struct { int owner; int ptr; int hold; } mst_t;
    typedef struct { int rr; int fx; int h1; } exp_t;

    mst_t m_rr, m_fx, m_h1;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mst_t model_reset();
        mst_t s;
        s.owner = -1;
        s.ptr   = 0;
        s.hold  = 0;
        return s;
    endfunction

    // One clock edge of the reference behaviour.
    function automatic mst_t model_step(input mst_t s, input logic [3:0] r, input bit fixed,
                                        input int maxh);
        mst_t n = s;
        int w = -1;
        int start = fixed ? 0 : s.ptr;
        for (int i = 0; i < 4; i++) begin
            int c = (start + i) % 4;
            if (w < 0 && r[c] && c != s.owner) w = c;
        end
        if (s.owner >= 0 && r[s.owner] && (w < 0 || s.hold < maxh - 1)) begin
            n.hold = (s.hold < maxh - 1) ? s.hold + 1 : s.hold;
        end else if (w >= 0) begin
            n.owner = w;
            n.ptr   = (w + 1) % 4;
            n.hold  = 0;
        end else begin
            n.owner = -1;
        end
        return n;
    endfunction

    function automatic logic [3:0] oh(input int o);
        logic [3:0] v = 4'b0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    task automatic check_dut(input string tag, input logic [3:0] g, input logic v,
                             input logic [1:0] id, input int o);
        check({tag, "_grant"}, 32'(g), 32'(oh(o)));
        check({tag, "_valid"}, 32'(v), 32'(o >= 0));
        check({tag, "_id"}, 32'(id), (o >= 0) ? o : 0);
    endtask

    task automatic check_inv(input string tag, input logic [3:0] g, input logic v,
                             input logic [1:0] id);
        logic ok;
        ok = $onehot0(g) && (v == (|g)) && ((g == 4'b0) ? (id == 2'd0) : g[id]);
        check(tag, 32'(ok), 32'd1);
    endtask

    // Drive req (called at a negedge), push expectation, compare at next negedge.
    task automatic step(input logic [3:0] r);
        exp_t e;
        req  = r;
        m_rr = model_step(m_rr, r, 1'b0, 4);
        m_fx = model_step(m_fx, r, 1'b1, 4);
        m_h1 = model_step(m_h1, r, 1'b0, 1);
        sb.push_back('{m_rr.owner, m_fx.owner, m_h1.owner});
        @(negedge clk);
        e = sb.pop_front();
        check_dut("rr", g_rr, v_rr, id_rr, e.rr);
        check_dut("fx", g_fx, v_fx, id_fx, e.fx);
        check_dut("h1", g_h1, v_h1, id_h1, e.h1);
        check_inv("inv_rr", g_rr, v_rr, id_rr);
        check_inv("inv_fx", g_fx, v_fx, id_fx);
        check_inv("inv_h1", g_h1, v_h1, id_h1);
    endtask

    // Assert reset between edges, expect outputs cleared at once, then release.
    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        check_dut("arst_rr", g_rr, v_rr, id_rr, -1);
        check_dut("arst_fx", g_fx, v_fx, id_fx, -1);
        check_dut("arst_h1", g_h1, v_h1, id_h1, -1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_rr  = model_reset();
        m_fx  = model_reset();
        m_h1  = model_reset();
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rot[4] = '{1, 2, 3, 0};
        int cnt;
        int n0010;
        int n1000;

        reset = 1'b1;
        req   = 4'b1111;
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_dut("in_rst", g_rr, v_rr, id_rr, -1);
        end
        reset = 1'b1;
        m_rr  = model_reset();
        m_fx  = model_reset();
        m_h1  = model_reset();

        // First grant right after release, then rotation with owner dropping.
        step(4'b1111);
        check("first_grant", 32'(g_rr), 32'h1);
        check("first_id", 32'(id_rr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(4'b1111 & ~oh(m_rr.owner));
            check("rot_id", 32'(id_rr), exp_rot[i]);
        end

        // Single one-cycle pulses.
        step(4'b0000);
        step(4'b0001);
        check("single0", 32'(g_rr), 32'h1);
        step(4'b0000);
        check("single0_off", 32'(g_rr), 32'h0);
        step(4'b0010);
        step(4'b0000);
        step(4'b0100);
        check("single2", 32'(g_rr), 32'h4);
        step(4'b0000);

        // Hold limit.
        apply_reset();
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step((i < 2) ? 4'b0100 : 4'b0101);
            if (g_rr == 4'b0100) cnt++;
        end
        check("hold_cycles", cnt, 4);
        check("hold_preempt", 32'(g_rr), 32'h1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'b0100);
            if (g_rr == 4'b0100) cnt++;
        end
        check("hold_alone", cnt, 12);

        // Fixed priority behaviour.
        n0010 = 0;
        n1000 = 0;
        for (int i = 0; i < 12; i++) begin
            step(4'b1010);
            if (g_fx == 4'b0010) n0010++;
            if (g_fx == 4'b1000) n1000++;
        end
        check("fx_alt", 32'((n0010 > 0) && (n1000 > 0)), 32'd1);
        n1000 = 0;
        for (int i = 0; i < 16; i++) begin
            step(4'b1011);
            if (g_fx == 4'b1000) n1000++;
        end
        check("fx_no3", n1000, 0);

        // Reset in the middle of a grant; pointer must restart from 0.
        step(4'b0000);
        step(4'b0100);
        check("pre_rst_grant", 32'(g_rr), 32'h4);
        apply_reset();
        step(4'b1010);
        check("ptr_restart", 32'(g_rr), 32'h2);
        step(4'b0100);
        check("grant_back", 32'(g_rr), 32'h4);
        step(4'b0000);
        step(4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
